// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle HI/LO multiply/divide unit for the E stage.
// Computes the 64-bit result at launch and commits it to HI/LO after a fixed latency.
module md_sequencer #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic        md_sel,
    input  logic [31:0] md1,
    input  logic [31:0] md2,
    output logic        busy,
    output logic [31:0] md_out
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, hi_tmp, lo_tmp;
    logic        div_zero;
    logic        div_by0, launch, mt_ok;
    logic [63:0] prod_s, prod_u, result;
    logic [31:0] a_abs, b_abs, s_div, u_div, q_u, r_u, q_s, r_s, dq_u, dr_u;
    always_comb begin
        prod_s  = {{32{md1[31]}}, md1} * {{32{md2[31]}}, md2};
        prod_u  = {32'd0, md1} * {32'd0, md2};
        div_by0 = md2 == 32'd0;
        // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case.
        a_abs   = md1[31] ? -md1 : md1;
        b_abs   = md2[31] ? -md2 : md2;
        s_div   = div_by0 ? 32'd1 : b_abs;
        u_div   = div_by0 ? 32'd1 : md2;
        q_u     = a_abs / s_div;
        r_u     = a_abs % s_div;
        q_s     = (md1[31] ^ md2[31]) ? -q_u : q_u;
        r_s     = md1[31] ? -r_u : r_u;
        dq_u    = md1 / u_div;
        dr_u    = md1 % u_div;
        result  = md_op[1] ? (md_op[0] ? {dr_u, dq_u} : {r_s, q_s})
                           : (md_op[0] ? prod_u : prod_s);
        launch  = start & ~req & (state == IDLE) & ~md_op[2];
        mt_ok   = md_we & ~req & (state == IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            hi_tmp   <= 32'd0;
            lo_tmp   <= 32'd0;
            div_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (launch) begin
                state            <= RUN;
                {hi_tmp, lo_tmp} <= result;
                cnt              <= md_op[1] ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);
                div_zero         <= md_op[1] & div_by0;
            end
            if (mt_ok && md_op == 3'd4) hi <= md1;
            if (mt_ok && md_op == 3'd5) lo <= md1;
        end else begin
            cnt <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
            if (cnt == 4'd0) begin
                state <= IDLE;
                if (!div_zero) begin
                    hi <= hi_tmp;
                    lo <= lo_tmp;
                end
            end
        end
    end
    assign busy   = state == RUN;
    assign md_out = md_sel ? hi : lo;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed test-plan checks plus randomized traffic against a behavioural HI/LO model.
module tb_md_sequencer;
    localparam int ML = 5;
    localparam int DL = 10;
    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, start = 1'b0, md_we = 1'b0, md_sel = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] md1 = 32'd0, md2 = 32'd0;
    logic        busy;
    logic [31:0] md_out;
    int          compared = 0, mismatched = 0;
    logic [31:0] mh = 32'd0, ml = 32'd0, ph = 32'd0, pl = 32'd0;
    bit          pz = 1'b0;
    int          rem = 0;

    md_sequencer #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .md_op(md_op), .md_we(md_we),
        .md_sel(md_sel), .md1(md1), .md2(md2), .busy(busy), .md_out(md_out)
    );

    always #5 clk = ~clk;

    // Reference: remaining busy cycles plus the pending result computed with 64-bit arithmetic.
    task automatic model_step();
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        bit was_busy;
        was_busy = rem > 0;
        if (reset) begin
            mh = 0; ml = 0; rem = 0;
            return;
        end
        if (was_busy) begin
            rem--;
            if (rem == 0 && !pz) begin mh = ph; ml = pl; end
        end else if (start && !req && md_op < 4) begin
            sa = longint'($signed(md1)); sb = longint'($signed(md2));
            ua = md1; ub = md2; pz = 1'b0;
            case (md_op)
                3'd0: begin p = longint'(sa * sb); {ph, pl} = p; end
                3'd1: begin p = ua * ub; {ph, pl} = p; end
                3'd2: if (sb == 0) pz = 1'b1; else begin q = sa / sb; r = sa % sb; pl = q[31:0]; ph = r[31:0]; end
                default: if (ub == 0) pz = 1'b1; else begin pl = md1 / md2; ph = md1 % md2; end
            endcase
            rem = (md_op < 2) ? ML : DL;
        end
        if (!was_busy && md_we && !req && md_op == 3'd4) mh = md1;
        if (!was_busy && md_we && !req && md_op == 3'd5) ml = md1;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compared++;
        if (busy !== (rem > 0)) begin
            mismatched++;
            $display("FAIL busy_cycle t=%0t got %b expected %b", $time, busy, rem > 0);
        end
        compared++;
        if (md_out !== (md_sel ? mh : ml)) begin
            mismatched++;
            $display("FAIL md_out_cycle t=%0t sel=%b got %h expected %h", $time, md_sel, md_out, md_sel ? mh : ml);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; md_op = op; md1 = a; md2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        md_we = 1'b1; md_op = op; md1 = a;
        @(negedge clk);
        md_we = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
        md_sel = 1'b0; #1; chk({name, "_lo"}, md_out, el);
        md_sel = 1'b1; #1; chk({name, "_hi"}, md_out, eh);
        md_sel = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        read_hl("reset", 32'd0, 32'd0);

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n); chk("mult_lat", n, ML);
        read_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n); chk("div_lat", n, DL);
        read_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n); read_hl("divu", 32'd1, 32'd3);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n); read_hl("div_ovf", 32'd0, 32'h80000000);

        mt(3'd4, 32'h12345678);
        mt(3'd5, 32'h9ABCDEF0);
        issue(3'd2, 32'd55, 32'd0);
        wait_idle(n); chk("div0_lat", n, DL);
        read_hl("div0", 32'h12345678, 32'h9ABCDEF0);

        req = 1'b1;
        issue(3'd0, 32'd5, 32'd5);
        req = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        read_hl("cancel", 32'h12345678, 32'h9ABCDEF0);

        issue(3'd0, 32'd5, 32'd5);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle(n); chk("req_run_rem", n, ML - 2);
        read_hl("req_run", 32'd0, 32'd25);

        issue(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(n); chk("ign_rem", n, ML - 2);
        read_hl("ignored", 32'd0, 32'd12);
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(n); chk("reissue_lat", n, ML);
        read_hl("reissue", 32'd1, 32'hFFFFFFFE);

        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        read_hl("rst_mid", 32'd0, 32'd0);
        repeat (8) @(negedge clk);
        read_hl("no_late", 32'd0, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] pool [4];
            pool[0] = 32'd0; pool[1] = 32'h80000000; pool[2] = 32'hFFFFFFFF; pool[3] = $urandom_range(1, 20);
            start  = ($urandom_range(0, 3) == 0);
            md_we  = ($urandom_range(0, 5) == 0);
            req    = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            md_sel = $urandom_range(0, 1);
            md_op  = 3'($urandom_range(0, 7));
            md1    = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            md2    = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            @(negedge clk);
        end
        start = 1'b0; md_we = 1'b0; req = 1'b0; reset = 1'b0;
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
